// File: rtl/line_window_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// line_window_buffer_ctrl
//
// Line-buffer controller for 2-D image kernels. Raster pixels are written
// into NBUF = KROWS+1 circular row memories; once KROWS complete rows are
// held, one KROWS x KCOLS window is presented per output handshake. The
// spare row memory is filled while the other KROWS are being read, so a
// steady stream needs no input stall unless the spare row is also full.
//
// Optional feature macro: LWB_EDGE_REPLICATE_EN
//   defined   : IMG_W windows per row pass, window centred on rd_col, column
//               index clamped to [0, IMG_W-1] (edge pixels replicated).
//               KCOLS must be odd.
//   undefined : IMG_W-KCOLS+1 windows per row pass, window left-aligned at
//               rd_col, no clamping.
//
// Ports
//   clk        in   1                   rising-edge clock
//   rst        in   1                   asynchronous active-low reset
//   clr        in   1                   synchronous clear of pointers/counters
//   in_data    in   PIX_W               raster pixel
//   in_valid   in   1                   in_data valid
//   in_ready   out  1                   block can accept in_data
//   out_data   out  KROWS*KCOLS*PIX_W   window; row r (0 = oldest) at
//                                       [r*KCOLS*PIX_W +: KCOLS*PIX_W],
//                                       column c LSB-first within the row
//   out_valid  out  1                   out_data valid
//   out_ready  in   1                   consumer accepts window
//   row_done   out  1                   pulse after last window of a pass
//   fsm_state  out  2                   debug view: FILL / STREAM / STALL_IN
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. in_ready and out_valid depend on registered state only, and
// out_valid/out_data never change while out_valid & !out_ready.
// ---------------------------------------------------------------------------
module line_window_buffer_ctrl #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 512,
    parameter int KROWS = 3,
    parameter int KCOLS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic [PIX_W-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [KROWS*KCOLS*PIX_W-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         row_done,
    output logic [1:0]                   fsm_state
);

    localparam int NBUF  = KROWS + 1;
    localparam int BUF_W = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int CNT_W = $clog2(NBUF + 1);
`ifdef LWB_EDGE_REPLICATE_EN
    localparam int WPR   = IMG_W;
    localparam int HALF  = KCOLS / 2;
`else
    localparam int WPR   = IMG_W - KCOLS + 1;
`endif

    // Implicit FSM encoding, derived from rows_filled.
    localparam logic [1:0] ST_FILL     = 2'd0;
    localparam logic [1:0] ST_STREAM   = 2'd1;
    localparam logic [1:0] ST_STALL_IN = 2'd2;

    logic [PIX_W-1:0] mem [NBUF][IMG_W];

    logic [COL_W-1:0] wr_col, rd_col;
    logic [BUF_W-1:0] wr_buf, rd_buf;
    logic [CNT_W-1:0] rows_filled;

    logic wr_acc, rd_acc, wr_last, rd_last;

    assign in_ready  = (rows_filled <  CNT_W'(NBUF));
    assign out_valid = (rows_filled >= CNT_W'(KROWS));

    assign wr_acc  = in_valid & in_ready;
    assign rd_acc  = out_valid & out_ready;
    assign wr_last = wr_acc && (wr_col == COL_W'(IMG_W - 1));
    assign rd_last = rd_acc && (rd_col == COL_W'(WPR - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_col      <= '0;
            wr_buf      <= '0;
            rd_col      <= '0;
            rd_buf      <= '0;
            rows_filled <= '0;
            row_done    <= 1'b0;
        end else if (clr) begin
            wr_col      <= '0;
            wr_buf      <= '0;
            rd_col      <= '0;
            rd_buf      <= '0;
            rows_filled <= '0;
            row_done    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_col <= wr_last ? '0 : wr_col + 1'b1;
            end
            if (wr_last) begin
                wr_buf <= (wr_buf == BUF_W'(NBUF - 1)) ? '0 : wr_buf + 1'b1;
            end
            if (rd_acc) begin
                rd_col <= rd_last ? '0 : rd_col + 1'b1;
            end
            if (rd_last) begin
                rd_buf <= (rd_buf == BUF_W'(NBUF - 1)) ? '0 : rd_buf + 1'b1;
            end
            // A row completing on the write side in the same cycle a row
            // retires on the read side leaves the occupancy unchanged.
            case ({wr_last, rd_last})
                2'b10:   rows_filled <= rows_filled + 1'b1;
                2'b01:   rows_filled <= rows_filled - 1'b1;
                default: rows_filled <= rows_filled;
            endcase
            row_done <= rd_last;
        end
    end

    // Row memories are not reset. Writes only ever target the spare row,
    // never one of the KROWS rows being read, so the window stays stable.
    always_ff @(posedge clk) begin
        if (rst && !clr && wr_acc) begin
            mem[wr_buf][wr_col] <= in_data;
        end
    end

    always_comb begin
        int b;
        int col;
        b        = 0;
        col      = 0;
        out_data = '0;
        if (out_valid) begin
            for (int r = 0; r < KROWS; r++) begin
                for (int c = 0; c < KCOLS; c++) begin
                    b = int'(rd_buf) + r;
                    if (b >= NBUF) begin
                        b = b - NBUF;
                    end
`ifdef LWB_EDGE_REPLICATE_EN
                    col = int'(rd_col) + c - HALF;
                    if (col < 0) begin
                        col = 0;
                    end
                    if (col > IMG_W - 1) begin
                        col = IMG_W - 1;
                    end
`else
                    col = int'(rd_col) + c;
`endif
                    out_data[(r*KCOLS + c)*PIX_W +: PIX_W] = mem[BUF_W'(b)][COL_W'(col)];
                end
            end
        end
    end

    always_comb begin
        fsm_state = ST_FILL;
        if (rows_filled == CNT_W'(NBUF)) begin
            fsm_state = ST_STALL_IN;
        end else if (out_valid) begin
            fsm_state = ST_STREAM;
        end
    end

endmodule
